// File: rtl/arbitration_table_config_pkg.sv
// Shared constants, state encoding and helpers for the arbitration table
// configuration controller and its register banks.
package arbitration_table_config_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_APPLY   = 2'd2
  } state_e;

  // Every slot powers up with the smallest legal weight.
  localparam int DEFAULT_PESO = 1;

  // Bit width needed to encode values 0..range-1, never narrower than one bit.
  function automatic int field_w(input int range);
    return (range <= 2) ? 1 : $clog2(range);
  endfunction

  // Width of a weight field.
  function automatic int peso_w(input int max_weight);
    return field_w(max_weight);
  endfunction

  // Width of a queue-selection field.
  function automatic int sel_w(input int queue_quantity);
    return field_w(queue_quantity);
  endfunction

  // Width of a table slot index.
  function automatic int slot_w(input int table_size);
    return field_w(table_size);
  endfunction

  // Default queue assignment: slots cycle through the queues in order.
  function automatic int default_sel(input int slot, input int queue_quantity);
    return slot % queue_quantity;
  endfunction

endpackage

// File: rtl/arbitration_table_bank.sv
// One arbitration table: TABLE_SIZE (weight, selection) entries with a
// single-entry write port, a load-all port and flattened packed outputs.
module arbitration_table_bank
  import arbitration_table_config_pkg::*;
#(
  parameter int ENTRIES        = 8,
  parameter int QUEUE_QUANTITY = 4,
  parameter int PESO_W         = 6,
  parameter int SEL_W          = 2,
  parameter int ADDR_W         = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [PESO_W-1:0]           wr_peso,
  input  logic [SEL_W-1:0]            wr_sel,
  input  logic                        load_en,
  input  logic [ENTRIES*PESO_W-1:0]   load_pesos,
  input  logic [ENTRIES*SEL_W-1:0]    load_sels,
  output logic [ENTRIES*PESO_W-1:0]   pesos,
  output logic [ENTRIES*SEL_W-1:0]    sels
);

  logic [PESO_W-1:0] peso_q [ENTRIES];
  logic [PESO_W-1:0] peso_d [ENTRIES];
  logic [SEL_W-1:0]  sel_q  [ENTRIES];
  logic [SEL_W-1:0]  sel_d  [ENTRIES];

  // Next table contents: a bulk load wins over a single-entry write.
  always_comb begin
    peso_d = peso_q;
    sel_d  = sel_q;
    if (load_en) begin
      for (int i = 0; i < ENTRIES; i++) begin
        peso_d[i] = load_pesos[i*PESO_W +: PESO_W];
        sel_d[i]  = load_sels[i*SEL_W +: SEL_W];
      end
    end else if (wr_en) begin
      peso_d[wr_addr] = wr_peso;
      sel_d[wr_addr]  = wr_sel;
    end
  end

  // Table storage; reset restores the default round-robin table.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        peso_q[i] <= PESO_W'(DEFAULT_PESO);
        sel_q[i]  <= SEL_W'(default_sel(i, QUEUE_QUANTITY));
      end
    end else begin
      peso_q <= peso_d;
      sel_q  <= sel_d;
    end
  end

  // Flatten the entries, slot n in bits [(n+1)*W-1 : n*W].
  always_comb begin
    pesos = '0;
    sels  = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      pesos[i*PESO_W +: PESO_W] = peso_q[i];
      sels[i*SEL_W +: SEL_W]    = sel_q[i];
    end
  end

endmodule

// File: rtl/arbitration_table_config.sv
// Arbitration table configuration controller: software fills a shadow table,
// and a commit swaps it into the active table at an arbiter wrap (or after a
// timeout), followed by a one-cycle arbiter reset so the weights reload.
module arbitration_table_config
  import arbitration_table_config_pkg::*;
#(
  parameter int QUEUE_QUANTITY = 4,
  parameter int MAX_WEIGHT     = 64,
  parameter int TABLE_SIZE     = 8,
  parameter int COMMIT_TIMEOUT = 255
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         wr_en,
  input  logic [slot_w(TABLE_SIZE)-1:0]                wr_addr,
  input  logic [peso_w(MAX_WEIGHT)-1:0]                wr_peso,
  input  logic [sel_w(QUEUE_QUANTITY)-1:0]             wr_sel,
  input  logic                                         commit,
  input  logic                                         table_wrap,
  output logic                                         busy,
  output logic                                         wr_err,
  output logic                                         done,
  output logic [TABLE_SIZE*peso_w(MAX_WEIGHT)-1:0]     pesos,
  output logic [TABLE_SIZE*sel_w(QUEUE_QUANTITY)-1:0]  selecciones,
  output logic                                         arb_rst,
  output logic                                         arb_enb
);

  localparam int PESO_W  = peso_w(MAX_WEIGHT);
  localparam int SEL_W   = sel_w(QUEUE_QUANTITY);
  localparam int ADDR_W  = slot_w(TABLE_SIZE);
  localparam int TIMER_W = field_w(COMMIT_TIMEOUT + 1);

  state_e               state_q, state_d;
  logic                 dirty_q, dirty_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 busy_q, busy_d;
  logic                 wr_err_q, wr_err_d;
  logic                 done_q, done_d;
  logic                 arb_rst_q, arb_rst_d;
  logic                 wr_ok;
  logic                 apply_go;

  logic [TABLE_SIZE*PESO_W-1:0] shadow_pesos;
  logic [TABLE_SIZE*SEL_W-1:0]  shadow_sels;

  arbitration_table_bank #(
    .ENTRIES        (TABLE_SIZE),
    .QUEUE_QUANTITY (QUEUE_QUANTITY),
    .PESO_W         (PESO_W),
    .SEL_W          (SEL_W),
    .ADDR_W         (ADDR_W)
  ) u_shadow (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_ok),
    .wr_addr    (wr_addr),
    .wr_peso    (wr_peso),
    .wr_sel     (wr_sel),
    .load_en    (1'b0),
    .load_pesos ('0),
    .load_sels  ('0),
    .pesos      (shadow_pesos),
    .sels       (shadow_sels)
  );

  arbitration_table_bank #(
    .ENTRIES        (TABLE_SIZE),
    .QUEUE_QUANTITY (QUEUE_QUANTITY),
    .PESO_W         (PESO_W),
    .SEL_W          (SEL_W),
    .ADDR_W         (ADDR_W)
  ) u_active (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (1'b0),
    .wr_addr    ('0),
    .wr_peso    ('0),
    .wr_sel     ('0),
    .load_en    (apply_go),
    .load_pesos (shadow_pesos),
    .load_sels  (shadow_sels),
    .pesos      (pesos),
    .sels       (selecciones)
  );

  // Commit FSM next state, write acceptance, timer and registered pulses.
  always_comb begin
    state_d  = state_q;
    dirty_d  = dirty_q;
    timer_d  = timer_q;
    done_d   = 1'b0;
    apply_go = 1'b0;
    // Writes only land while idle and with a non-zero weight.
    wr_ok    = wr_en && (state_q == ST_IDLE) && (wr_peso != '0);
    wr_err_d = wr_en && !wr_ok;
    unique case (state_q)
      ST_IDLE: begin
        if (wr_ok) dirty_d = 1'b1;
        // A write in the commit cycle counts as dirty and rides along.
        if (commit) begin
          if (dirty_q || wr_ok) begin
            state_d = ST_PENDING;
            timer_d = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_PENDING: begin
        if (timer_q != {TIMER_W{1'b1}}) timer_d = timer_q + 1'b1;
        if (table_wrap || (timer_q == TIMER_W'(COMMIT_TIMEOUT))) begin
          state_d  = ST_APPLY;
          apply_go = 1'b1;
          dirty_d  = 1'b0;
        end
      end
      ST_APPLY: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d    = (state_d != ST_IDLE);
    arb_rst_d = (state_d == ST_APPLY);
  end

  // Control registers; the arbiter is held in reset while we are.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      dirty_q   <= 1'b0;
      timer_q   <= '0;
      busy_q    <= 1'b0;
      wr_err_q  <= 1'b0;
      done_q    <= 1'b0;
      arb_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      dirty_q   <= dirty_d;
      timer_q   <= timer_d;
      busy_q    <= busy_d;
      wr_err_q  <= wr_err_d;
      done_q    <= done_d;
      arb_rst_q <= arb_rst_d;
    end
  end

  assign busy    = busy_q;
  assign wr_err  = wr_err_q;
  assign done    = done_q;
  assign arb_rst = arb_rst_q;
  assign arb_enb = ~arb_rst_q;

endmodule

// File: tb/tb_arbitration_table_config.sv
// Bench for arbitration_table_config: directed steps plus randomized
// write/commit rounds checked against a transaction-level table model.
module tb_arbitration_table_config;

  localparam int QQ = 4;
  localparam int MW = 64;
  localparam int TS = 8;
  localparam int TO = 4;
  localparam int PW = 6;
  localparam int SW = 2;
  localparam int AW = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [PW-1:0]     wr_peso;
  logic [SW-1:0]     wr_sel;
  logic              commit;
  logic              table_wrap;
  logic              busy;
  logic              wr_err;
  logic              done;
  logic [TS*PW-1:0]  pesos;
  logic [TS*SW-1:0]  selecciones;
  logic              arb_rst;
  logic              arb_enb;

  int tests = 0;
  int fails = 0;

  // Reference model: the two tables and the dirty flag.
  int m_sh_p [TS];
  int m_sh_s [TS];
  int m_ac_p [TS];
  int m_ac_s [TS];
  bit m_dirty;

  arbitration_table_config #(
    .QUEUE_QUANTITY (QQ),
    .MAX_WEIGHT     (MW),
    .TABLE_SIZE     (TS),
    .COMMIT_TIMEOUT (TO)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_peso     (wr_peso),
    .wr_sel      (wr_sel),
    .commit      (commit),
    .table_wrap  (table_wrap),
    .busy        (busy),
    .wr_err      (wr_err),
    .done        (done),
    .pesos       (pesos),
    .selecciones (selecciones),
    .arb_rst     (arb_rst),
    .arb_enb     (arb_enb)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] flat_p(input bit shadow);
    logic [63:0] r = '0;
    for (int i = 0; i < TS; i++) r[i*PW +: PW] = PW'(shadow ? m_sh_p[i] : m_ac_p[i]);
    return r;
  endfunction

  function automatic logic [63:0] flat_s(input bit shadow);
    logic [63:0] r = '0;
    for (int i = 0; i < TS; i++) r[i*SW +: SW] = SW'(shadow ? m_sh_s[i] : m_ac_s[i]);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < TS; i++) begin
      m_sh_p[i] = 1;
      m_sh_s[i] = i % QQ;
      m_ac_p[i] = 1;
      m_ac_s[i] = i % QQ;
    end
    m_dirty = 1'b0;
  endtask

  // One write from IDLE; zero weights must be rejected.
  task automatic do_write(input int a, input int p, input int s);
    bit err;
    err     = (p == 0);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_peso = PW'(p);
    wr_sel  = SW'(s);
    step();
    wr_en = 1'b0;
    if (!err) begin
      m_sh_p[a] = p;
      m_sh_s[a] = s;
      m_dirty   = 1'b1;
    end
    chk("wr_err", 64'(wr_err), 64'(err));
    chk("shadow_pesos", 64'(u_dut.u_shadow.pesos), flat_p(1'b1));
    chk("idle_pesos", 64'(pesos), flat_p(1'b0));
  endtask

  // Called in the first PENDING cycle; wrap at PENDING cycle wrap_k (or the
  // timeout fires at cycle TO), an illegal write at cycle bad_k.
  task automatic do_pending(input int wrap_k, input int bad_k);
    for (int k = 0; k <= TO; k++) begin
      chk("pend_busy", 64'(busy), 64'(1));
      chk("pend_arb_rst", 64'(arb_rst), 64'(0));
      chk("pend_arb_enb", 64'(arb_enb), 64'(1));
      chk("pend_done", 64'(done), 64'(0));
      chk("pend_pesos", 64'(pesos), flat_p(1'b0));
      chk("pend_sels", 64'(selecciones), flat_s(1'b0));
      table_wrap = (k == wrap_k);
      if (k == bad_k) begin
        wr_en   = 1'b1;
        wr_addr = AW'($urandom_range(0, TS - 1));
        wr_peso = PW'($urandom_range(1, MW - 1));
        wr_sel  = SW'($urandom_range(0, QQ - 1));
      end
      step();
      table_wrap = 1'b0;
      wr_en      = 1'b0;
      chk("pend_wr_err", 64'(wr_err), 64'(k == bad_k));
      if (k == wrap_k || k == TO) break;
    end
    for (int i = 0; i < TS; i++) begin
      m_ac_p[i] = m_sh_p[i];
      m_ac_s[i] = m_sh_s[i];
    end
    m_dirty = 1'b0;
    chk("apply_arb_rst", 64'(arb_rst), 64'(1));
    chk("apply_arb_enb", 64'(arb_enb), 64'(0));
    chk("apply_busy", 64'(busy), 64'(1));
    chk("apply_done", 64'(done), 64'(0));
    chk("apply_pesos", 64'(pesos), flat_p(1'b0));
    chk("apply_sels", 64'(selecciones), flat_s(1'b0));
    step();
    chk("post_done", 64'(done), 64'(1));
    chk("post_arb_rst", 64'(arb_rst), 64'(0));
    chk("post_arb_enb", 64'(arb_enb), 64'(1));
    chk("post_busy", 64'(busy), 64'(0));
    step();
    chk("post2_done", 64'(done), 64'(0));
    chk("shadow_kept", 64'(u_dut.u_shadow.pesos), flat_p(1'b1));
  endtask

  task automatic do_commit(input int wrap_k, input int bad_k);
    commit = 1'b1;
    step();
    commit = 1'b0;
    if (!m_dirty) begin
      chk("clean_done", 64'(done), 64'(1));
      chk("clean_busy", 64'(busy), 64'(0));
      chk("clean_arb_rst", 64'(arb_rst), 64'(0));
      step();
      chk("clean_done2", 64'(done), 64'(0));
      chk("clean_busy2", 64'(busy), 64'(0));
      return;
    end
    do_pending(wrap_k, bad_k);
  endtask

  initial begin
    rst        = 1'b1;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_peso    = '0;
    wr_sel     = '0;
    commit     = 1'b0;
    table_wrap = 1'b0;
    model_reset();

    // Reset held two cycles: default table, arbiter held in reset.
    step();
    step();
    chk("rst_pesos", 64'(pesos), flat_p(1'b0));
    chk("rst_sels", 64'(selecciones), 64'(16'he4e4));
    chk("rst_arb_rst", 64'(arb_rst), 64'(1));
    chk("rst_arb_enb", 64'(arb_enb), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_wr_err", 64'(wr_err), 64'(0));
    rst = 1'b0;
    step();
    chk("run_arb_rst", 64'(arb_rst), 64'(0));
    chk("run_arb_enb", 64'(arb_enb), 64'(1));

    // Slot 2 <= (10, 3), commit, wrap in the first PENDING cycle.
    do_write(2, 10, 3);
    do_commit(0, -1);
    chk("slot2_peso", 64'(pesos[2*PW +: PW]), 64'(10));
    chk("slot2_sel", 64'(selecciones[2*SW +: SW]), 64'(3));

    // Zero-weight write is rejected; commit with nothing dirty.
    do_write(4, 0, 1);
    do_commit(-1, -1);

    // Write during PENDING rejected; no wrap so the timeout applies.
    do_write(6, 63, 2);
    do_commit(-1, 1);

    // Wrap outside PENDING is ignored.
    table_wrap = 1'b1;
    step();
    table_wrap = 1'b0;
    chk("idle_wrap_busy", 64'(busy), 64'(0));
    chk("idle_wrap_arb_rst", 64'(arb_rst), 64'(0));

    // Write and commit in the same cycle: the write rides along.
    wr_en   = 1'b1;
    commit  = 1'b1;
    wr_addr = AW'(7);
    wr_peso = PW'(21);
    wr_sel  = SW'(1);
    step();
    wr_en  = 1'b0;
    commit = 1'b0;
    m_sh_p[7] = 21;
    m_sh_s[7] = 1;
    m_dirty   = 1'b1;
    chk("wc_wr_err", 64'(wr_err), 64'(0));
    do_pending(2, -1);

    // Reset during PENDING aborts with no done and restores defaults.
    do_write(5, 33, 0);
    commit = 1'b1;
    step();
    commit = 1'b0;
    chk("abort_busy", 64'(busy), 64'(1));
    step();
    rst = 1'b1;
    step();
    model_reset();
    chk("abort_pesos", 64'(pesos), flat_p(1'b0));
    chk("abort_sels", 64'(selecciones), flat_s(1'b0));
    chk("abort_busy2", 64'(busy), 64'(0));
    chk("abort_arb_rst", 64'(arb_rst), 64'(1));
    chk("abort_done", 64'(done), 64'(0));
    rst = 1'b0;
    step();
    chk("abort_done2", 64'(done), 64'(0));
    chk("abort_arb_rst2", 64'(arb_rst), 64'(0));
    chk("abort_shadow", 64'(u_dut.u_shadow.pesos), flat_p(1'b1));
    do_commit(0, -1);

    // Randomized rounds of writes and commits.
    for (int it = 0; it < 30; it++) begin
      int n;
      n = $urandom_range(0, 3);
      for (int j = 0; j < n; j++) begin
        int a, p, s;
        a = $urandom_range(0, TS - 1);
        p = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, MW - 1);
        s = $urandom_range(0, QQ - 1);
        do_write(a, p, s);
      end
      if ($urandom_range(0, 3) == 0) begin
        table_wrap = 1'b1;
        step();
        table_wrap = 1'b0;
        chk("rnd_idle_wrap", 64'(busy), 64'(0));
      end
      do_commit($urandom_range(0, 6), $urandom_range(0, 7));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
